multicycle_controller: RTL and testbench

Control FSM for the multicycle RV32I subset core: decodes the latched instruction fields and sequences the datapath over 3–5 cycles per instruction. It produces the 3-bit ALUControl that the datapath ALU consumes, and it consumes that ALU's Zero flag to resolve branches. It also drives all datapath mux selects and write enables.

---
 rtl/multicycle_controller_pkg.sv | 114 +++++++++++
 rtl/multicycle_controller_if.sv | 30 +++
 rtl/multicycle_controller_alu_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 84 ++++++++
 tb/tb_multicycle_controller.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller and its datapath.
package multicycle_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_FAULT    = 4'd11
  } state_e;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10} result_src_e;
  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_REG = 2'b10} src_a_e;
  typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} src_b_e;

  // Moore control word held in registers alongside the state
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    aluop_e     alu_op;
  } ctrl_t;

  // Control word asserted while the FSM sits in state s
  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_FOUR;
        c.pc_update = 1'b1;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_SUB;
        c.branch    = 1'b1;
      end
      S_FAULT:    c.illegal = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle.
interface multicycle_if;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic       Funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       IllegalOp;

  modport master (
    input  Op, Funct3, Funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, IllegalOp
  );

  modport slave (
    output Op, Funct3, Funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, IllegalOp
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps ALUOp plus instruction function fields to the ALU operation.
module alu_decoder
  import multicycle_pkg::*;
(
  input  aluop_e     alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  // Op[5] separates R-type sub from I-type addi with imm[10] set
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control_o = ALU_AND;
          3'b110:  alu_control_o = ALU_OR;
          3'b100:  alu_control_o = ALU_XOR;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default:   alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback.
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  multicycle_if.master  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;

  // Next-state decode; unused encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR:   state_d = bus.Op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with the Moore control word registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  // The reset value of the control word is FETCH's, so enables are masked by
  // rst_n directly to be low during reset and live in the first FETCH cycle.
  assign bus.AdrSrc    = ctrl_q.adr_src;
  assign bus.MemWrite  = ctrl_q.mem_write & rst_n;
  assign bus.IRWrite   = ctrl_q.ir_write  & rst_n;
  assign bus.RegWrite  = ctrl_q.reg_write & rst_n;
  assign bus.IllegalOp = ctrl_q.illegal   & rst_n;
  assign bus.ResultSrc = ctrl_q.result_src;
  assign bus.ALUSrcA   = ctrl_q.alu_src_a;
  assign bus.ALUSrcB   = ctrl_q.alu_src_b;
  assign bus.PCWrite   = rst_n & (ctrl_q.pc_update |
                                  (ctrl_q.branch & (bus.Zero ^ bus.Funct3[0])));

  // Immediate format selected straight from the opcode
  always_comb begin
    case (bus.Op)
      OP_SW:   bus.ImmSrc = IMM_S;
      OP_BR:   bus.ImmSrc = IMM_B;
      OP_JAL:  bus.ImmSrc = IMM_J;
      default: bus.ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (ctrl_q.alu_op),
    .funct3_i      (bus.Funct3),
    .op5_i         (bus.Op[5]),
    .funct7b5_i    (bus.Funct7b5),
    .alu_control_o (bus.ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-cycle comparison against an instruction schedule model.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_JAL = 5, C_BAD = 6;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] op_of(input int c);
    case (c)
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_BR:    return 7'b1100011;
      C_JAL:   return 7'b1101111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int instr_len(input int c);
    case (c)
      C_LW:    return 5;
      C_BR:    return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic op5, input logic f7);
    case (f3)
      3'd0:    return (op5 && f7) ? 3'd1 : 3'd0;
      3'd7:    return 3'd2;
      3'd6:    return 3'd3;
      3'd4:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,IllegalOp}
  function automatic logic [16:0] dut_pack();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegWrite, bus.IllegalOp};
  endfunction

  // Expected outputs in cycle k of an instruction of class c
  function automatic logic [16:0] model(input int c, input int k, input logic [6:0] op,
                                        input logic [2:0] f3, input logic f7, input logic zero);
    logic pc = 0, adr = 0, mw = 0, ir = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, imm = 0;
    logic [2:0] aluc = 0;
    if (op == 7'b0100011) imm = 2'd1;
    else if (op == 7'b1100011) imm = 2'd2;
    else if (op == 7'b1101111) imm = 2'd3;
    if (k == 0) begin
      pc = 1; ir = 1; sb = 2; rs = 2;
    end else if (k == 1) begin
      sa = 1; sb = 1;
    end else if (c == C_BAD) begin
      ill = 1;
    end else begin
      case (c)
        C_LW, C_SW: begin
          if (k == 2) begin sa = 2; sb = 1; end
          else if (c == C_LW && k == 3) adr = 1;
          else if (c == C_LW) begin rs = 1; rw = 1; end
          else begin adr = 1; mw = 1; end
        end
        C_R, C_I: begin
          if (k == 2) begin
            sa = 2; sb = (c == C_I) ? 2'd1 : 2'd0; aluc = funct_alu(f3, op[5], f7);
          end else rw = 1;
        end
        C_JAL: begin
          if (k == 2) begin sa = 1; sb = 2; pc = 1; end
          else rw = 1;
        end
        default: begin
          sa = 2; sb = 0; aluc = 3'd1; pc = zero ^ f3[0];
        end
      endcase
    end
    return {pc, adr, mw, ir, rs, sa, sb, aluc, imm, rw, ill};
  endfunction

  // Enters just after a rising edge with the FSM in FETCH; checks nk cycles.
  // With stop_k >= 0 it returns mid-cycle after checking cycle stop_k.
  task automatic run_instr(input int c, input logic [2:0] f3, input logic f7,
                           input int zforce, input int nk, input int stop_k);
    logic [6:0] op;
    logic z;
    op = op_of(c);
    bus.Op = op;
    bus.Funct3 = f3;
    bus.Funct7b5 = f7;
    for (int k = 0; k < nk; k++) begin
      z = 1'($urandom_range(0, 1));
      if (zforce >= 0 && c == C_BR && k == 2) z = zforce[0];
      bus.Zero = z;
      @(negedge clk);
      check_eq($sformatf("c%0d f3=%0d k%0d", c, f3, k), 32'(dut_pack()), 32'(model(c, k, op, f3, f7, z)));
      bus.Zero = ~z;
      #1;
      check_eq($sformatf("c%0d f3=%0d k%0d zflip", c, f3, k), 32'(dut_pack()), 32'(model(c, k, op, f3, f7, ~z)));
      if (k == stop_k) return;
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset pulse: enables must drop at once, FETCH resumes on release
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_eq({tag, " enables"}, 32'({bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.IllegalOp}), 32'd0);
    check_eq({tag, " muxes"}, 32'({bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl}),
             32'({1'b0, 2'b10, 2'b00, 2'b10, 3'b000}));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.Op = '0;
    bus.Funct3 = '0;
    bus.Funct7b5 = 1'b0;
    bus.Zero = 1'b0;
    rst_n = 1'b1;
    #2;
    pulse_reset("reset");

    run_instr(C_R, 3'd0, 1'b0, -1, 4, -1);   // add
    run_instr(C_R, 3'd0, 1'b1, -1, 4, -1);   // sub
    run_instr(C_R, 3'd4, 1'b0, -1, 4, -1);   // xor
    run_instr(C_R, 3'd7, 1'b0, -1, 4, -1);   // and
    run_instr(C_R, 3'd6, 1'b1, -1, 4, -1);   // or
    run_instr(C_I, 3'd0, 1'b1, -1, 4, -1);   // addi with imm[10] set
    run_instr(C_LW, 3'd2, 1'b0, -1, 5, -1);
    run_instr(C_SW, 3'd2, 1'b0, -1, 4, -1);
    run_instr(C_BR, 3'd0, 1'b0, 1, 3, -1);   // beq taken
    run_instr(C_BR, 3'd0, 1'b0, 0, 3, -1);   // beq not taken
    run_instr(C_BR, 3'd1, 1'b0, 0, 3, -1);   // bne taken
    run_instr(C_BR, 3'd1, 1'b0, 1, 3, -1);   // bne not taken
    run_instr(C_JAL, 3'd0, 1'b0, -1, 4, -1);

    for (int n = 0; n < 80; n++) begin
      int c;
      c = int'($urandom_range(0, 5));
      run_instr(c, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, instr_len(c), -1);
    end

    // Illegal opcode parks in the fault state until reset
    run_instr(C_BAD, 3'd0, 1'b0, -1, 7, 6);
    pulse_reset("fault reset");
    run_instr(C_R, 3'd0, 1'b1, -1, 4, -1);

    // Reset landing in the middle of a store
    run_instr(C_SW, 3'd2, 1'b0, -1, 4, 3);
    pulse_reset("memwrite reset");
    run_instr(C_LW, 3'd2, 1'b0, -1, 5, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
